gnr_attractor_ctrl: RTL and testbench
=====================================

Name: gnr_attractor_ctrl

Overview:
- Sequencer that drives a bank of NUM_NODES boolean-network node cells through their control inputs: reset_nos, start_s0, start_s1 and the per-node init_state.
- Reads the cells' s0 (slow copy) and s1 (fast copy) state vectors back and runs tortoise/hare cycle detection on them.
- Measures the attractor period and returns the result per initial state over a valid/ready stream.
- Sits between the host-side initial-state stream and the generated node array.

Parameters:
- NUM_NODES, 188, number of node cells; width of every state vector.
- CNT_W, 16, width of the step and period counters.
- MAX_STEPS, 65535, timeout limit for both the RUN and PERIOD phases; must be < 2^CNT_W.
- ID_W, 32, width of the initial-state tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  initial state offered.
- in_ready  out  1  controller accepts an initial state.
- in_state  in  NUM_NODES  initial state vector.
- in_id  in  ID_W  tag echoed on the result.
- reset_nos  out  1  load pulse to all node cells.
- start_s0  out  1  advance slow copy (the cells divide it by 2 internally).
- start_s1  out  1  advance fast copy.
- init_state  out  NUM_NODES  bit i drives init_state of node i.
- s0_vec  in  NUM_NODES  concatenated node s0 outputs.
- s1_vec  in  NUM_NODES  concatenated node s1 outputs.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_id  out  ID_W  echoed tag.
- out_steps  out  CNT_W  tortoise steps n at first meeting.
- out_period  out  CNT_W  attractor length; 0 on timeout.
- out_state  out  NUM_NODES  s0 snapshot at meeting (a state on the attractor).
- out_timeout  out  1  limit reached.

Behaviour:
- Reset: rst_n low asynchronously forces IDLE. All outputs go to 0 except in_ready, which is 1 in IDLE. Counters and latched vectors clear. Reset mid-run abandons the job; no result is emitted.
- States: IDLE, LOAD, RUN, PERIOD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_state into init_state and in_id, then go to LOAD.
- LOAD:
  - reset_nos=1 for exactly one cycle. init_state stays stable from LOAD onward until the next accept.
  - Clear run_cnt and per_cnt, then go to RUN.
- RUN:
  - start_s0=start_s1=1 every cycle.
  - run_cnt counts start edges already applied.
  - Cell semantics: s0 updates on odd edges only; s1 updates on every edge. After an even run_cnt=2n, s0 holds step n and s1 holds step 2n.
  - Compare s0_vec==s1_vec only in cycles where run_cnt is even and nonzero.
  - On match: deassert both starts in the same cycle, latch out_state=s0_vec and out_steps=run_cnt/2, then go to PERIOD.
  - If run_cnt reaches MAX_STEPS without a match, go to DONE with timeout.
- PERIOD:
  - start_s0=0, so s0 is frozen as reference. start_s1=1 each cycle; per_cnt counts s1 edges applied.
  - Compare every cycle with per_cnt>=1. On match, out_period=per_cnt; deassert start_s1; go to DONE.
  - per_cnt reaching MAX_STEPS gives timeout.
  - A fixed point yields out_period=1.
- DONE:
  - out_valid=1; all out_* held stable until out_ready. Starts and reset_nos are 0.
  - On out_valid&out_ready go to IDLE. in_ready asserts in the next cycle, so there is one bubble per job.
- Timeout: out_timeout=1, out_period=0. out_steps and out_state hold the values at the time of timeout.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Compare uses the vectors visible in the current cycle. The cells' output is registered, so the value is already post-edge and no extra latency applies.
- Counters saturate at MAX_STEPS and never wrap.

Decomposition:
- Package gnr_ctrl_pkg: state enum (IDLE, LOAD, RUN, PERIOD, DONE), CNT_W/ID_W defaults, result struct {id, steps, period, state, timeout}.
- One natural sub-module: gnr_vec_eq, a parameterized NUM_NODES-wide equality reduction reused for both compares.

Test Plan:
- Bench model with NUM_NODES=4 computes next = rotate-left of state. in_state=4'b0001, id=7 -> reset_nos one pulse; match at run_cnt=8 (n=4); out_steps=4, out_period=4, out_state=4'b0001, out_timeout=0.
- Fixed-point model (next=state), in_state=4'b1010 -> match at run_cnt=2; out_steps=1, out_period=1, out_state=4'b1010.
- Model next=state+1 mod 16 behind a 4-step transient into a 3-cycle, with MAX_STEPS=12 -> correct mu-region meeting, out_period=3. Non-cyclic counter model with MAX_STEPS=12 -> out_timeout=1, out_period=0.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and all out_* stable, in_ready=0, no start pulses. Release -> handshake, then in_ready=1 in the following cycle.
- Back-to-back jobs, in_valid held high with ids 1,2,3 -> three results in order, each preceded by exactly one reset_nos pulse.
- Drop rst_n during PERIOD -> all outputs 0 immediately, in_ready=1 after release, no out_valid for the aborted job.

Source files
------------

// File: rtl/gnr_ctrl_pkg.sv
// Shared types and default sizes for the boolean-network attractor controller.
package gnr_ctrl_pkg;

    localparam int NUM_NODES_DEF = 188;
    localparam int CNT_W_DEF     = 16;
    localparam int ID_W_DEF      = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        PERIOD,
        DONE
    } state_t;

    // Result record at the default sizes, for host-side code that talks to a
    // default-configured controller.
    typedef struct packed {
        logic [ID_W_DEF-1:0]      id;
        logic [CNT_W_DEF-1:0]     steps;
        logic [CNT_W_DEF-1:0]     period;
        logic [NUM_NODES_DEF-1:0] state;
        logic                     timeout;
    } result_t;

endpackage

// File: rtl/gnr_vec_eq.sv
// Wide equality reduction between two state vectors.
module gnr_vec_eq #(
    parameter int W = 188
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq
);

    // Equal when no bit position differs.
    always_comb begin
        eq = ~|(a ^ b);
    end

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Tortoise/hare attractor sequencer for a bank of boolean-network node cells.
// RUN advances the slow copy (s0, halved inside the cells) and the fast copy
// (s1) until they meet; PERIOD freezes s0 and steps s1 until it comes back
// around, which gives the attractor length.
module gnr_attractor_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int NUM_NODES = NUM_NODES_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int MAX_STEPS = 65535,
    parameter int ID_W      = ID_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_NODES-1:0] in_state,
    input  logic [ID_W-1:0]      in_id,
    output logic                 reset_nos,
    output logic                 start_s0,
    output logic                 start_s1,
    output logic [NUM_NODES-1:0] init_state,
    input  logic [NUM_NODES-1:0] s0_vec,
    input  logic [NUM_NODES-1:0] s1_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic [CNT_W-1:0]     out_steps,
    output logic [CNT_W-1:0]     out_period,
    output logic [NUM_NODES-1:0] out_state,
    output logic                 out_timeout
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [CNT_W-1:0]     steps;
        logic [CNT_W-1:0]     period;
        logic [NUM_NODES-1:0] state;
        logic                 timeout;
    } job_result_t;

    state_t           state;
    job_result_t      res_q;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] per_cnt;

    logic vec_match;
    logic run_hit;
    logic run_limit;
    logic per_hit;
    logic per_limit;

    // One comparator serves both phases: s0 against s1 as seen this cycle.
    gnr_vec_eq #(
        .W (NUM_NODES)
    ) u_vec_eq (
        .a  (s0_vec),
        .b  (s1_vec),
        .eq (vec_match)
    );

    // Meeting/limit decisions; starts must drop in the very cycle a meeting
    // is seen, otherwise one extra step would already be applied to the cells.
    always_comb begin
        run_hit   = (state == RUN) && (run_cnt != '0) && !run_cnt[0] && vec_match;
        run_limit = (state == RUN) && (run_cnt == MAX_CNT);
        per_hit   = (state == PERIOD) && (per_cnt != '0) && vec_match;
        per_limit = (state == PERIOD) && (per_cnt == MAX_CNT);
        start_s0  = (state == RUN) && !run_hit && !run_limit;
        start_s1  = start_s0 || ((state == PERIOD) && !per_hit && !per_limit);
    end

    // Job sequencer: accept, load the cells, search for the meeting point,
    // measure the period, then hold the result until it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            reset_nos  <= 1'b0;
            out_valid  <= 1'b0;
            init_state <= '0;
            res_q      <= '0;
            run_cnt    <= '0;
            per_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        init_state <= in_state;
                        res_q      <= '0;
                        res_q.id   <= in_id;
                        in_ready   <= 1'b0;
                        reset_nos  <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    reset_nos <= 1'b0;
                    run_cnt   <= '0;
                    per_cnt   <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (run_hit) begin
                        res_q.steps <= run_cnt >> 1;
                        res_q.state <= s0_vec;
                        state       <= PERIOD;
                    end else if (run_limit) begin
                        res_q.steps   <= run_cnt >> 1;
                        res_q.state   <= s0_vec;
                        res_q.period  <= '0;
                        res_q.timeout <= 1'b1;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                end
                PERIOD: begin
                    if (per_hit) begin
                        res_q.period <= per_cnt;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else if (per_limit) begin
                        res_q.period  <= '0;
                        res_q.timeout <= 1'b1;
                        out_valid     <= 1'b1;
                        state         <= DONE;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result fields come straight from the held record.
    always_comb begin
        out_id      = res_q.id;
        out_steps   = res_q.steps;
        out_period  = res_q.period;
        out_state   = res_q.state;
        out_timeout = res_q.timeout;
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a 4-node behavioural cell bank.
module tb_gnr_attractor_ctrl;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int IW = 32;
    localparam int MS = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_state;
    logic [IW-1:0] in_id;
    logic          reset_nos;
    logic          start_s0;
    logic          start_s1;
    logic [N-1:0]  init_state;
    logic [N-1:0]  s0_vec = '0;
    logic [N-1:0]  s1_vec = '0;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_id;
    logic [CW-1:0] out_steps;
    logic [CW-1:0] out_period;
    logic [N-1:0]  out_state;
    logic          out_timeout;

    logic          ph = 1'b0;
    int            model_mode = 0;
    int            total = 0;
    int            bad = 0;
    int            rn_count = 0;
    int            s0_edges = 0;
    int            s1_edges = 0;
    int            valid_count = 0;

    // mode 0: rotate-left ring, 1: fixed point, 2: 4-step tail into a
    // 3-cycle (4->5->6->4), 3: plain counter mod 16
    typedef struct {
        int            mode;
        logic [N-1:0]  init;
        logic [IW-1:0] id;
        logic [CW-1:0] steps;
        logic [CW-1:0] period;
        logic [N-1:0]  state;
        logic          timeout;
        int            s0e;
        int            s1e;
    } vec_t;

    vec_t vecs[4];

    gnr_attractor_ctrl #(
        .NUM_NODES (N),
        .CNT_W     (CW),
        .MAX_STEPS (MS),
        .ID_W      (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .in_id       (in_id),
        .reset_nos   (reset_nos),
        .start_s0    (start_s0),
        .start_s1    (start_s1),
        .init_state  (init_state),
        .s0_vec      (s0_vec),
        .s1_vec      (s1_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_steps   (out_steps),
        .out_period  (out_period),
        .out_state   (out_state),
        .out_timeout (out_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] next_fn(input int mode, input logic [N-1:0] s);
        case (mode)
            0:       next_fn = {s[N-2:0], s[N-1]};
            1:       next_fn = s;
            2:       next_fn = (s < 4'd6) ? s + 4'd1 : 4'd4;
            default: next_fn = s + 4'd1;
        endcase
    endfunction

    // Node cell bank: load on reset_nos, s0 advances on every other start_s0.
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            ph     <= 1'b0;
        end else begin
            if (start_s1) s1_vec <= next_fn(model_mode, s1_vec);
            if (start_s0) begin
                ph <= ~ph;
                if (!ph) s0_vec <= next_fn(model_mode, s0_vec);
            end
        end
    end

    // Count control pulses and result cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_nos) rn_count++;
        if (start_s0)  s0_edges++;
        if (start_s1)  s1_edges++;
        if (out_valid) valid_count++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic waitReady();
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        checkOutput("wait_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic waitValid();
        int n = 0;
        while (!out_valid && n < 200) begin tick(); n++; end
        checkOutput("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        checkOutput("in_ready_during_handshake", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        checkOutput("out_valid_after_handshake", 64'(out_valid), 64'd0);
        checkOutput("in_ready_after_handshake", 64'(in_ready), 64'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input bit do_release);
        int rn_b, s0_b, s1_b;
        model_mode = v.mode;
        waitReady();
        rn_b = rn_count; s0_b = s0_edges; s1_b = s1_edges;
        in_valid = 1'b1; in_state = v.init; in_id = v.id;
        tick();
        in_valid = 1'b0;
        waitValid();
        checkOutput("out_id", 64'(out_id), 64'(v.id));
        checkOutput("out_steps", 64'(out_steps), 64'(v.steps));
        checkOutput("out_period", 64'(out_period), 64'(v.period));
        checkOutput("out_state", 64'(out_state), 64'(v.state));
        checkOutput("out_timeout", 64'(out_timeout), 64'(v.timeout));
        checkOutput("s0_edges", 64'(s0_edges - s0_b), 64'(v.s0e));
        checkOutput("s1_edges", 64'(s1_edges - s1_b), 64'(v.s1e));
        checkOutput("reset_nos_pulses", 64'(rn_count - rn_b), 64'd1);
        if (do_release) releaseResult();
    endtask

    initial begin
        vec_t bp;
        int   rn_b, v_b, n;
        logic [N-1:0] st;

        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_id = '0; out_ready = 1'b0;

        // ring of 4: meet at n=4; fixed point: n=1; tail 4 + cycle 3 meets at
        // n=6, i.e. run_cnt == MAX_STEPS, which still counts as a meeting;
        // counter never meets before the limit, s0 = 6 there
        vecs[0] = '{0, 4'b0001, 32'd7,  16'd4, 16'd4, 4'b0001, 1'b0, 8,  12};
        vecs[1] = '{1, 4'b1010, 32'd8,  16'd1, 16'd1, 4'b1010, 1'b0, 2,  3};
        vecs[2] = '{2, 4'b0000, 32'd21, 16'd6, 16'd3, 4'd6,    1'b0, 12, 15};
        vecs[3] = '{3, 4'b0000, 32'd33, 16'd6, 16'd0, 4'd6,    1'b1, 12, 12};

        tick(); tick();
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_outputs", 64'({reset_nos, start_s0, start_s1, init_state, out_valid,
                    out_id, out_steps, out_period, out_state, out_timeout}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b1);

        // backpressure: result must sit still with no activity toward the cells
        bp = '{0, 4'b0100, 32'd9, 16'd4, 16'd4, 4'b0100, 1'b0, 8, 12};
        applyStimulus(bp, 1'b0);
        rn_b = rn_count;
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_result", 64'({out_id, out_steps, out_period, out_state, out_timeout}),
                        64'({32'd9, 16'd4, 16'd4, 4'b0100, 1'b0}));
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_starts", 64'({start_s0, start_s1}), 64'd0);
        end
        checkOutput("bp_no_reset_nos", 64'(rn_count - rn_b), 64'd0);
        releaseResult();

        // back-to-back jobs with in_valid held high throughout
        model_mode = 1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            st = 4'(k * 5);
            in_id = 32'(k); in_state = st;
            rn_b = rn_count;
            waitReady();
            tick();
            waitValid();
            checkOutput("b2b_id", 64'(out_id), 64'(k));
            checkOutput("b2b_state", 64'(out_state), 64'(st));
            checkOutput("b2b_period", 64'(out_period), 64'd1);
            checkOutput("b2b_reset_nos", 64'(rn_count - rn_b), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_idle", 64'(in_ready), 64'd1);

        // abort during PERIOD
        model_mode = 0;
        waitReady();
        in_valid = 1'b1; in_state = 4'b0010; in_id = 32'd5;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!(start_s1 && !start_s0) && n < 40) begin tick(); n++; end
        checkOutput("reached_period", 64'({start_s0, start_s1}), 64'b01);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", 64'({reset_nos, start_s0, start_s1, init_state, out_valid,
                    out_id, out_steps, out_period, out_state, out_timeout}), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        tick(); tick();
        rst_n = 1'b1;
        v_b = valid_count;
        tick();
        checkOutput("post_abort_in_ready", 64'(in_ready), 64'd1);
        repeat (30) tick();
        checkOutput("post_abort_no_result", 64'(valid_count - v_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
